component_decode_sequencer: RTL and testbench

Controls decoding of one colour component of a ProRes slice on the decoder side. It holds the DC and AC variable-length decoders in or out of reset, accepts decoded DC values and AC (run, level) pairs over valid/ready handshakes, and expands them into one coefficient write per cycle. Writes use ProRes interleaved scan order (block-major within each frequency) into the downstream dequantiser/IDCT coefficient buffer.

---
 rtl/component_decode_sequencer_pkg.sv | 17 +
 rtl/component_decode_sequencer_if.sv | 54 +++++
 rtl/component_decode_sequencer_coef_position_counter.sv | 44 ++++
 rtl/component_decode_sequencer.sv | 176 +++++++++++++++++
 tb/tb_component_decode_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/component_decode_sequencer_pkg.sv
// Shared types and constants for the ProRes component decode sequencer.
// Covers the state encoding, block limits and coefficient width.
package component_decode_pkg;

   localparam int MAX_BLOCKS = 32;
   localparam int AC_COEFS   = 63;
   localparam int COEF_W     = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_DC   = 3'd1,
      ST_AC   = 3'd2,
      ST_ZERO = 3'd3,
      ST_DONE = 3'd4
   } state_e;

endpackage

// File: rtl/component_decode_sequencer_if.sv
// VLD handshakes and coefficient write bus between the sequencer
// (master) and the VLDs plus coefficient buffer (slave).
interface component_decode_sequencer_if;
   import component_decode_pkg::*;

   logic              dc_vld_reset;
   logic              dc_vld_valid;
   logic [COEF_W-1:0] dc_vld_value;
   logic              dc_vld_ready;

   logic              ac_vld_reset;
   logic              ac_vld_valid;
   logic [5:0]        ac_vld_run;
   logic [COEF_W-1:0] ac_vld_level;
   logic              ac_vld_ready;

   logic              coef_we;
   logic [4:0]        coef_block;
   logic [5:0]        coef_freq;
   logic [COEF_W-1:0] coef_value;

   modport master (
      output dc_vld_reset,
      output dc_vld_ready,
      input  dc_vld_valid,
      input  dc_vld_value,
      output ac_vld_reset,
      output ac_vld_ready,
      input  ac_vld_valid,
      input  ac_vld_run,
      input  ac_vld_level,
      output coef_we,
      output coef_block,
      output coef_freq,
      output coef_value
   );

   modport slave (
      input  dc_vld_reset,
      input  dc_vld_ready,
      output dc_vld_valid,
      output dc_vld_value,
      input  ac_vld_reset,
      input  ac_vld_ready,
      output ac_vld_valid,
      output ac_vld_run,
      output ac_vld_level,
      input  coef_we,
      input  coef_block,
      input  coef_freq,
      input  coef_value
   );

endinterface

// File: rtl/component_decode_sequencer_coef_position_counter.sv
// Interleaved scan position: block counter wrapping at N that bumps
// freq on wrap, plus a count of positions left in the component.
module coef_position_counter (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        load,
   input  logic [5:0]  load_num,
   input  logic        inc,
   output logic [4:0]  block,
   output logic [5:0]  freq,
   output logic [11:0] left,
   output logic        block_last,
   output logic        pos_last
);

   logic [5:0] num;

   assign block_last = ({1'b0, block} == num - 6'd1);
   assign pos_last   = (left == 12'd1);

   // DC wraps freq 0->1, so AC starts at block 0 / freq 1 with 63*N left
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         num   <= '0;
         block <= '0;
         freq  <= '0;
         left  <= '0;
      end else if (load) begin
         num   <= load_num;
         block <= '0;
         freq  <= '0;
         left  <= {load_num, 6'd0};
      end else if (inc) begin
         left <= left - 12'd1;
         if (block_last) begin
            block <= '0;
            freq  <= freq + 6'd1;
         end else begin
            block <= block + 5'd1;
         end
      end
   end

endmodule

// File: rtl/component_decode_sequencer.sv
// Sequences DC then AC VLD decoding for one colour component and
// expands (run, level) pairs into one coefficient write per cycle.
module component_decode_sequencer
   import component_decode_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] block_num,
   component_decode_sequencer_if.master bus,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam logic [2:0] S_IDLE = ST_IDLE;
   localparam logic [2:0] S_DC   = ST_DC;
   localparam logic [2:0] S_AC   = ST_AC;
   localparam logic [2:0] S_ZERO = ST_ZERO;
   localparam logic [2:0] S_DONE = ST_DONE;

   logic [2:0]        state;
   logic [2:0]        state_d;
   logic              done_q;
   logic              error_q;
   logic [5:0]        rem;
   logic [COEF_W-1:0] level_q;

   logic              accept;
   logic              bad;
   logic              dc_hs;
   logic              ac_hs;
   logic              ac_wr;
   logic              overrun;
   logic              zero_st;
   logic              inc;
   logic              ld;

   logic [4:0]        blk;
   logic [5:0]        frq;
   logic [11:0]       left;
   logic              blk_last;
   logic              pos_last;

   logic              we_q;
   logic [4:0]        block_q;
   logic [5:0]        freq_q;
   logic [COEF_W-1:0] value_q;

   assign busy  = (state != S_IDLE) | done_q;
   assign done  = done_q;
   assign error = error_q;

   assign bus.dc_vld_reset = (state == S_DC);
   assign bus.dc_vld_ready = (state == S_DC);
   assign bus.ac_vld_reset = (state == S_AC) | (state == S_ZERO);
   assign bus.ac_vld_ready = (state == S_AC);

   assign bus.coef_we    = we_q;
   assign bus.coef_block = block_q;
   assign bus.coef_freq  = freq_q;
   assign bus.coef_value = value_q;

   assign accept  = start & ~busy;
   assign bad     = (block_num == 32'd0) |
                    (block_num > 32'(MAX_BLOCKS));
   assign dc_hs   = bus.dc_vld_valid & (state == S_DC);
   assign ac_hs   = bus.ac_vld_valid & (state == S_AC);
   // p + r + 1 > 63*N  <=>  r >= positions left
   assign overrun = ({6'd0, bus.ac_vld_run} >= left);
   assign ac_wr   = ac_hs & ~overrun;
   assign zero_st = (state == S_ZERO);
   assign inc     = dc_hs | ac_wr | zero_st;
   assign ld      = accept & ~bad;

   coef_position_counter u_pos (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (ld),
      .load_num   (block_num[5:0]),
      .inc        (inc),
      .block      (blk),
      .freq       (frq),
      .left       (left),
      .block_last (blk_last),
      .pos_last   (pos_last)
   );

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE: begin
            if (accept) state_d = bad ? S_DONE : S_DC;
         end
         S_DC: begin
            if (dc_hs && blk_last) state_d = S_AC;
         end
         S_AC: begin
            if (ac_hs) begin
               if (overrun)
                  state_d = S_DONE;
               else if (bus.ac_vld_run != 6'd0)
                  state_d = S_ZERO;
               else if (pos_last)
                  state_d = S_DONE;
            end
         end
         S_ZERO: begin
            if (rem == 6'd0) state_d = pos_last ? S_DONE : S_AC;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         rem     <= '0;
         level_q <= '0;
      end else begin
         state  <= state_d;
         done_q <= (state == S_DONE);
         if (accept)
            error_q <= bad;
         else if (ac_hs && overrun)
            error_q <= 1'b1;
         if (ac_hs) begin
            rem     <= bus.ac_vld_run - 6'd1;
            level_q <= bus.ac_vld_level;
         end else if (zero_st && rem != 6'd0) begin
            rem <= rem - 6'd1;
         end
      end
   end

   // The write at the current position carries a zero until the run ends
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         we_q    <= 1'b0;
         block_q <= '0;
         freq_q  <= '0;
         value_q <= '0;
      end else begin
         we_q    <= 1'b0;
         block_q <= '0;
         freq_q  <= '0;
         value_q <= '0;
         unique case (1'b1)
            dc_hs: begin
               we_q    <= 1'b1;
               block_q <= blk;
               freq_q  <= frq;
               value_q <= bus.dc_vld_value;
            end
            ac_wr: begin
               we_q    <= 1'b1;
               block_q <= blk;
               freq_q  <= frq;
               value_q <= (bus.ac_vld_run == 6'd0) ?
                          bus.ac_vld_level : '0;
            end
            zero_st: begin
               we_q    <= 1'b1;
               block_q <= blk;
               freq_q  <= frq;
               value_q <= (rem == 6'd0) ? level_q : '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_component_decode_sequencer.sv
// Directed bench for component_decode_sequencer with VLD stream
// feeders, a write monitor and immediate-assertion checks.
module tb_component_decode_sequencer;
   import component_decode_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic [31:0] block_num;
   logic        busy;
   logic        done;
   logic        error;

   component_decode_sequencer_if bus ();

   component_decode_sequencer dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .block_num (block_num),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [COEF_W-1:0] dc_q[$];
   logic [5:0]        run_q[$];
   logic [COEF_W-1:0] lvl_q[$];
   int                epoch = 0;
   bit                rnd = 1'b0;

   logic [4:0]        wq_blk[$];
   logic [5:0]        wq_frq[$];
   logic [COEF_W-1:0] wq_val[$];
   int                wq_cyc[$];
   int                done_cnt = 0;
   int                done_cyc = 0;
   int                start_cyc = 0;
   int                err_cyc = 0;
   int                rdy_low = 0;
   logic [1:0]        err_rst = 2'b11;
   logic              err_prev = 1'b0;

   logic [4:0]        eb[$];
   logic [5:0]        ef[$];
   logic [COEF_W-1:0] ev[$];

   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      if (bus.coef_we) begin
         wq_blk.push_back(bus.coef_block);
         wq_frq.push_back(bus.coef_freq);
         wq_val.push_back(bus.coef_value);
         wq_cyc.push_back(cyc);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (start && !busy) start_cyc = cyc;
      if (error && !err_prev) begin
         err_cyc = cyc;
         err_rst = {bus.dc_vld_reset, bus.ac_vld_reset};
      end
      err_prev = error;
      if (bus.ac_vld_reset && !bus.ac_vld_ready) rdy_low++;
   end

   int dc_i = 0;
   int ac_i = 0;
   int seen = 0;

   initial begin : feeder
      bit dtook;
      bit atook;
      bus.dc_vld_valid = 1'b0;
      bus.dc_vld_value = '0;
      bus.ac_vld_valid = 1'b0;
      bus.ac_vld_run   = '0;
      bus.ac_vld_level = '0;
      forever begin
         @(negedge clock);
         dtook = bus.dc_vld_valid && bus.dc_vld_ready;
         atook = bus.ac_vld_valid && bus.ac_vld_ready;
         @(posedge clock);
         #1;
         if (epoch != seen) begin
            dc_i = 0;
            ac_i = 0;
            seen = epoch;
         end else begin
            if (dtook) dc_i++;
            if (atook) ac_i++;
         end
         bus.dc_vld_valid = (dc_i < dc_q.size()) &&
                            (!rnd || $urandom_range(0, 1) == 1);
         bus.dc_vld_value = (dc_i < dc_q.size()) ? dc_q[dc_i] : '0;
         bus.ac_vld_valid = (ac_i < run_q.size()) &&
                            (!rnd || $urandom_range(0, 1) == 1);
         bus.ac_vld_run   = (ac_i < run_q.size()) ? run_q[ac_i] : '0;
         bus.ac_vld_level = (ac_i < lvl_q.size()) ? lvl_q[ac_i] : '0;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic stim_clear();
      dc_q.delete();
      run_q.delete();
      lvl_q.delete();
   endtask

   task automatic exp_clear();
      eb.delete();
      ef.delete();
      ev.delete();
   endtask

   task automatic exp_push(input int b, input int f,
                           input logic [COEF_W-1:0] v);
      eb.push_back(5'(b));
      ef.push_back(6'(f));
      ev.push_back(v);
   endtask

   task automatic pulse_start(input int n);
      block_num = n;
      start = 1'b1;
      @(posedge clock);
      #2;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int d0,
                            input int budget);
      int k = 0;
      while (done_cnt == d0 && k < budget) begin
         @(negedge clock);
         k++;
      end
      chk({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
      @(posedge clock);
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic check_writes(input string tag, input int w0);
      int n;
      n = wq_blk.size() - w0;
      chk({tag, "_count"}, n, eb.size());
      for (int i = 0; i < eb.size() && i < n; i++) begin
         chk($sformatf("%s_blk%0d", tag, i), wq_blk[w0+i], eb[i]);
         chk($sformatf("%s_frq%0d", tag, i), wq_frq[w0+i], ef[i]);
         chk($sformatf("%s_val%0d", tag, i), wq_val[w0+i], ev[i]);
      end
   endtask

   task automatic outputs_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_we"}, bus.coef_we, 0);
      chk({tag, "_value"}, bus.coef_value, 0);
      chk({tag, "_dcrst"}, bus.dc_vld_reset, 0);
      chk({tag, "_dcrdy"}, bus.dc_vld_ready, 0);
      chk({tag, "_acrst"}, bus.ac_vld_reset, 0);
      chk({tag, "_acrdy"}, bus.ac_vld_ready, 0);
   endtask

   task automatic stim_n4();
      stim_clear();
      dc_q.push_back(16'd10);
      dc_q.push_back(16'hFFFD);
      dc_q.push_back(16'd0);
      dc_q.push_back(16'd7);
      for (int p = 0; p < 252; p++) begin
         run_q.push_back(6'd0);
         lvl_q.push_back(16'd1);
      end
      exp_clear();
      exp_push(0, 0, 16'd10);
      exp_push(1, 0, 16'hFFFD);
      exp_push(2, 0, 16'd0);
      exp_push(3, 0, 16'd7);
      for (int p = 0; p < 252; p++) exp_push(p % 4, 1 + p / 4, 16'd1);
   endtask

   task automatic stim_long_run();
      stim_clear();
      dc_q.push_back(16'd5);
      run_q.push_back(6'd62);
      lvl_q.push_back(16'hFFFE);
      exp_clear();
      exp_push(0, 0, 16'd5);
      for (int f = 1; f <= 62; f++) exp_push(0, f, 16'd0);
      exp_push(0, 63, 16'hFFFE);
   endtask

   initial begin : main
      int w0;
      int d0;
      int r0;
      int k;
      reset_n = 1'b0;
      start = 1'b0;
      block_num = '0;
      idle(3);
      outputs_zero("reset");
      reset_n = 1'b1;
      idle(2);

      // N = 4, all-zero-run pairs, gap-free
      stim_n4();
      epoch++;
      w0 = wq_blk.size();
      d0 = done_cnt;
      pulse_start(4);
      wait_done("t1", d0, 400);
      check_writes("t1", w0);
      chk("t1_latency", done_cyc - start_cyc, 258);
      if (wq_cyc.size() > w0)
         chk("t1_first_wr", wq_cyc[w0] - start_cyc, 2);
      chk("t1_error", error, 0);
      idle(3);
      chk("t1_busy_after", busy, 0);

      // N = 1, one long zero run ending at freq 63
      stim_long_run();
      epoch++;
      w0 = wq_blk.size();
      d0 = done_cnt;
      r0 = rdy_low;
      pulse_start(1);
      wait_done("t2", d0, 200);
      check_writes("t2", w0);
      chk("t2_rdy_low", rdy_low - r0, 62);
      if (wq_cyc.size() >= w0 + 64)
         chk("t2_burst", wq_cyc[w0+63] - wq_cyc[w0+1], 62);
      chk("t2_error", error, 0);
      idle(3);

      // N = 2, run overruns the component at p = 100
      stim_clear();
      dc_q.push_back(16'd1);
      dc_q.push_back(16'd2);
      for (int p = 0; p < 100; p++) begin
         run_q.push_back(6'd0);
         lvl_q.push_back(16'd3);
      end
      run_q.push_back(6'd63);
      lvl_q.push_back(16'd9);
      exp_clear();
      exp_push(0, 0, 16'd1);
      exp_push(1, 0, 16'd2);
      for (int p = 0; p < 100; p++) exp_push(p % 2, 1 + p / 2, 16'd3);
      epoch++;
      w0 = wq_blk.size();
      d0 = done_cnt;
      pulse_start(2);
      wait_done("t3", d0, 300);
      check_writes("t3", w0);
      chk("t3_error", error, 1);
      chk("t3_done_after_err", done_cyc - err_cyc, 1);
      chk("t3_vld_resets", err_rst, 2'b00);
      idle(3);
      chk("t3_sticky", error, 1);

      // Illegal block counts
      stim_clear();
      epoch++;
      w0 = wq_blk.size();
      d0 = done_cnt;
      pulse_start(0);
      wait_done("t4a", d0, 20);
      chk("t4a_latency", done_cyc - start_cyc, 2);
      chk("t4a_error", error, 1);
      chk("t4a_writes", wq_blk.size() - w0, 0);
      idle(3);
      w0 = wq_blk.size();
      d0 = done_cnt;
      pulse_start(33);
      wait_done("t4b", d0, 20);
      chk("t4b_latency", done_cyc - start_cyc, 2);
      chk("t4b_error", error, 1);
      chk("t4b_writes", wq_blk.size() - w0, 0);
      idle(3);

      // Random valid gaps plus a start while busy
      stim_n4();
      rnd = 1'b1;
      epoch++;
      w0 = wq_blk.size();
      d0 = done_cnt;
      pulse_start(4);
      idle(30);
      pulse_start(7);
      wait_done("t5", d0, 3000);
      rnd = 1'b0;
      check_writes("t5", w0);
      chk("t5_one_done", done_cnt - d0, 1);
      chk("t5_error", error, 0);
      idle(3);

      // Reset in the middle of a zero run, then a clean N = 2 component
      stim_long_run();
      epoch++;
      pulse_start(1);
      k = 0;
      while (!(bus.ac_vld_reset && !bus.ac_vld_ready) && k < 50) begin
         @(negedge clock);
         k++;
      end
      chk("t6_in_zero", 32'(bus.ac_vld_reset && !bus.ac_vld_ready), 1);
      idle(10);
      reset_n = 1'b0;
      #1;
      outputs_zero("t6_reset");
      @(posedge clock);
      #2;
      stim_clear();
      exp_clear();
      dc_q.push_back(16'd3);
      dc_q.push_back(16'd4);
      exp_push(0, 0, 16'd3);
      exp_push(1, 0, 16'd4);
      for (int p = 0; p < 126; p++) begin
         run_q.push_back(6'd0);
         lvl_q.push_back(16'(p + 1));
         exp_push(p % 2, 1 + p / 2, 16'(p + 1));
      end
      epoch++;
      reset_n = 1'b1;
      idle(2);
      w0 = wq_blk.size();
      d0 = done_cnt;
      pulse_start(2);
      wait_done("t6", d0, 300);
      check_writes("t6", w0);
      chk("t6_latency", done_cyc - start_cyc, 130);
      chk("t6_error", error, 0);
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
